// File: rtl/lsq_pkg.sv
// Shared types and helpers for the load/store queue.
// The LSQ_FORWARD_EN macro selects store-to-load forwarding in lsq_multi_port.
package lsq_pkg;

  typedef enum logic [2:0] {
    LQ_FREE   = 3'd0,
    LQ_ALLOC  = 3'd1,
    LQ_ADDR   = 3'd2,
    LQ_ISSUED = 3'd3,
    LQ_DONE   = 3'd4
  } lq_state_t;

  typedef enum logic [1:0] {
    SQ_FREE      = 2'd0,
    SQ_ALLOC     = 2'd1,
    SQ_ADDR      = 2'd2,
    SQ_COMMITTED = 2'd3
  } sq_state_t;

  typedef struct packed {
    lq_state_t state;
  } lq_entry_t;

  typedef struct packed {
    sq_state_t state;
  } sq_entry_t;

  // True when index pos lies in [head, tail); head/tail carry a wrap bit, depth is a power of two.
  function automatic logic age_in_window(input int unsigned pos, input int unsigned head,
                                         input int unsigned tail, input int unsigned depth);
    int unsigned cnt;
    int unsigned off;
    cnt = (tail - head) % (2 * depth);
    off = (pos - head) % depth;
    return off < cnt;
  endfunction

endpackage

// File: rtl/lsq_age_select.sv
// Rotate-by-head priority picker: returns the oldest (or youngest) set request bit
// counting from head around a power-of-two ring.
module lsq_age_select #(
  parameter int unsigned N        = 8,
  parameter bit          YOUNGEST = 1'b0
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] head,
  output logic                 found,
  output logic [$clog2(N)-1:0] sel
);
  localparam int unsigned IW = $clog2(N);

  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int k = 0; k < N; k++) begin
      if (req[head + IW'(k)] && (YOUNGEST || !found)) begin
        found = 1'b1;
        sel   = head + IW'(k);
      end
    end
  end

endmodule

// File: rtl/lsq_multi_port.sv
// Load/store queue with separate LQ/SQ rings, ready/valid D-cache port and snapshot squash.
// Define LSQ_FORWARD_EN for byte-enable store-to-load forwarding; otherwise same-word stores block.
module lsq_multi_port
  import lsq_pkg::*;
#(
  parameter int unsigned LQ_DEPTH   = 8,
  parameter int unsigned SQ_DEPTH   = 8,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TAG_WIDTH  = 6
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          alloc_valid,
  input  logic                          alloc_is_store,
  input  logic [TAG_WIDTH-1:0]          alloc_tag,
  output logic                          alloc_ready,
  output logic [$clog2(LQ_DEPTH):0]     alloc_lq_idx,
  output logic [$clog2(SQ_DEPTH):0]     alloc_sq_idx,
  input  logic                          agu_valid,
  input  logic                          agu_is_store,
  input  logic [((LQ_DEPTH > SQ_DEPTH) ? $clog2(LQ_DEPTH) : $clog2(SQ_DEPTH))-1:0] agu_idx,
  input  logic [ADDR_WIDTH-1:0]         agu_addr,
  input  logic [DATA_WIDTH/8-1:0]       agu_be,
  input  logic [DATA_WIDTH-1:0]         agu_data,
  input  logic                          commit_store,
  input  logic                          commit_load,
  input  logic                          flush_valid,
  input  logic [$clog2(LQ_DEPTH):0]     flush_lq_tail,
  input  logic [$clog2(SQ_DEPTH):0]     flush_sq_tail,
  output logic                          dc_req_valid,
  input  logic                          dc_req_ready,
  output logic                          dc_req_write,
  output logic [ADDR_WIDTH-1:0]         dc_req_addr,
  output logic [DATA_WIDTH/8-1:0]       dc_req_be,
  output logic [DATA_WIDTH-1:0]         dc_req_data,
  output logic [$clog2(LQ_DEPTH)-1:0]   dc_req_lq_idx,
  input  logic                          dc_resp_valid,
  input  logic [$clog2(LQ_DEPTH)-1:0]   dc_resp_lq_idx,
  input  logic [DATA_WIDTH-1:0]         dc_resp_data,
  output logic                          ld_wb_valid,
  output logic [TAG_WIDTH-1:0]          ld_wb_tag,
  output logic [DATA_WIDTH-1:0]         ld_wb_data,
  output logic                          lq_full,
  output logic                          sq_full
);
  localparam int unsigned LQ_IW = $clog2(LQ_DEPTH);
  localparam int unsigned SQ_IW = $clog2(SQ_DEPTH);
  localparam int unsigned LQ_PW = LQ_IW + 1;
  localparam int unsigned SQ_PW = SQ_IW + 1;
  localparam int unsigned BE_W  = DATA_WIDTH / 8;
  localparam int unsigned OFF_W = $clog2(BE_W);

  lq_entry_t             lq      [LQ_DEPTH];
  logic [ADDR_WIDTH-1:0] lq_addr [LQ_DEPTH];
  logic [BE_W-1:0]       lq_be   [LQ_DEPTH];
  logic [TAG_WIDTH-1:0]  lq_tag  [LQ_DEPTH];
  logic [SQ_PW-1:0]      lq_snap [LQ_DEPTH];
  sq_entry_t             sq      [SQ_DEPTH];
  logic [ADDR_WIDTH-1:0] sq_addr [SQ_DEPTH];
  logic [BE_W-1:0]       sq_be   [SQ_DEPTH];
  logic [DATA_WIDTH-1:0] sq_data [SQ_DEPTH];

  logic [LQ_PW-1:0] lq_head, lq_tail;
  logic [SQ_PW-1:0] sq_head, sq_tail, sq_cmt;
  logic [LQ_IW-1:0] lq_head_i, lq_tail_i, agu_lq_i, ld_sel;
  logic [SQ_IW-1:0] sq_head_i, sq_tail_i, sq_cmt_i, agu_sq_i;

  logic [LQ_DEPTH-1:0] ld_cand, lq_kill;
  logic [SQ_DEPTH-1:0] sq_kill, st_older, st_unknown, st_word;
  logic                ld_found, ld_blocked, ld_fwd;
  logic [DATA_WIDTH-1:0] fwd_data;
  logic resp_go, req_free, st_go, ld_go, fwd_go, drain, alloc_fire;

  assign lq_head_i = lq_head[LQ_IW-1:0];
  assign lq_tail_i = lq_tail[LQ_IW-1:0];
  assign sq_head_i = sq_head[SQ_IW-1:0];
  assign sq_tail_i = sq_tail[SQ_IW-1:0];
  assign sq_cmt_i  = sq_cmt[SQ_IW-1:0];
  assign agu_lq_i  = agu_idx[LQ_IW-1:0];
  assign agu_sq_i  = agu_idx[SQ_IW-1:0];

  assign lq_full      = (lq_head_i == lq_tail_i) && (lq_head[LQ_IW] != lq_tail[LQ_IW]);
  assign sq_full      = (sq_head_i == sq_tail_i) && (sq_head[SQ_IW] != sq_tail[SQ_IW]);
  assign alloc_ready  = alloc_is_store ? !sq_full : !lq_full;
  assign alloc_lq_idx = lq_tail;
  assign alloc_sq_idx = sq_tail;

  // Load candidates and the squash windows of this cycle's flush.
  always_comb begin
    ld_cand = '0;
    lq_kill = '0;
    sq_kill = '0;
    for (int i = 0; i < LQ_DEPTH; i++) begin
      ld_cand[i] = (lq[i].state == LQ_ADDR);
      lq_kill[i] = flush_valid && age_in_window(32'(i), 32'(flush_lq_tail), 32'(lq_tail), LQ_DEPTH);
    end
    for (int j = 0; j < SQ_DEPTH; j++) begin
      sq_kill[j] = flush_valid && (sq[j].state != SQ_COMMITTED) &&
                   age_in_window(32'(j), 32'(flush_sq_tail), 32'(sq_tail), SQ_DEPTH);
    end
  end

  lsq_age_select #(.N(LQ_DEPTH), .YOUNGEST(1'b0)) u_ld_pick (
    .req(ld_cand), .head(lq_head_i), .found(ld_found), .sel(ld_sel)
  );

  // Older stores of the selected load: those between sq_head and its allocation snapshot.
  always_comb begin
    st_older   = '0;
    st_unknown = '0;
    st_word    = '0;
    for (int j = 0; j < SQ_DEPTH; j++) begin
      st_older[j]   = age_in_window(32'(j), 32'(sq_head), 32'(lq_snap[ld_sel]), SQ_DEPTH);
      st_unknown[j] = st_older[j] && (sq[j].state == SQ_ALLOC);
      st_word[j]    = st_older[j] && (sq[j].state == SQ_ADDR || sq[j].state == SQ_COMMITTED) &&
                      (sq_addr[j][ADDR_WIDTH-1:OFF_W] == lq_addr[ld_sel][ADDR_WIDTH-1:OFF_W]);
    end
  end

`ifdef LSQ_FORWARD_EN
  logic [SQ_DEPTH-1:0] st_ovl;
  logic                fw_found;
  logic [SQ_IW-1:0]    fw_idx;

  always_comb begin
    st_ovl = '0;
    for (int j = 0; j < SQ_DEPTH; j++) begin
      st_ovl[j] = st_word[j] && (|(sq_be[j] & lq_be[ld_sel]));
    end
  end

  lsq_age_select #(.N(SQ_DEPTH), .YOUNGEST(1'b1)) u_fw_pick (
    .req(st_ovl), .head(sq_head_i), .found(fw_found), .sel(fw_idx)
  );

  // The youngest overlapping older store either covers the load (forward) or blocks it.
  always_comb begin
    ld_blocked = |st_unknown;
    ld_fwd     = 1'b0;
    fwd_data   = '0;
    if (fw_found) begin
      if ((sq_be[fw_idx] & lq_be[ld_sel]) == lq_be[ld_sel]) ld_fwd = !ld_blocked;
      else ld_blocked = 1'b1;
    end
    for (int b = 0; b < BE_W; b++) begin
      fwd_data[b*8 +: 8] = lq_be[ld_sel][b] ? sq_data[fw_idx][b*8 +: 8] : 8'h00;
    end
  end
`else
  always_comb begin
    ld_blocked = (|st_unknown) || (|st_word);
    ld_fwd     = 1'b0;
    fwd_data   = '0;
  end
`endif

  // Request register is refilled only when empty, so an accepted entry is never re-picked.
  assign req_free   = !dc_req_valid;
  assign st_go      = req_free && (sq[sq_head_i].state == SQ_COMMITTED);
  assign ld_go      = req_free && !st_go && ld_found && !ld_blocked && !ld_fwd && !flush_valid;
  assign resp_go    = dc_resp_valid && (lq[dc_resp_lq_idx].state == LQ_ISSUED) && !lq_kill[dc_resp_lq_idx];
  assign fwd_go     = ld_found && ld_fwd && !resp_go && !flush_valid;
  assign drain      = dc_req_valid && dc_req_ready && dc_req_write;
  assign alloc_fire = alloc_valid && alloc_ready && !flush_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lq_head <= '0;
      lq_tail <= '0;
      sq_head <= '0;
      sq_tail <= '0;
      sq_cmt  <= '0;
      for (int i = 0; i < LQ_DEPTH; i++) begin
        lq[i].state <= LQ_FREE;
        lq_addr[i]  <= '0;
        lq_be[i]    <= '0;
        lq_tag[i]   <= '0;
        lq_snap[i]  <= '0;
      end
      for (int j = 0; j < SQ_DEPTH; j++) begin
        sq[j].state <= SQ_FREE;
        sq_addr[j]  <= '0;
        sq_be[j]    <= '0;
        sq_data[j]  <= '0;
      end
      dc_req_valid  <= 1'b0;
      dc_req_write  <= 1'b0;
      dc_req_addr   <= '0;
      dc_req_be     <= '0;
      dc_req_data   <= '0;
      dc_req_lq_idx <= '0;
      ld_wb_valid   <= 1'b0;
      ld_wb_tag     <= '0;
      ld_wb_data    <= '0;
    end else begin
      ld_wb_valid <= 1'b0;
      if (dc_req_valid && dc_req_ready) dc_req_valid <= 1'b0;

      if (agu_valid && agu_is_store) begin
        if (sq[agu_sq_i].state == SQ_ALLOC && !sq_kill[agu_sq_i]) begin
          sq[agu_sq_i].state <= SQ_ADDR;
          sq_addr[agu_sq_i]  <= agu_addr;
          sq_be[agu_sq_i]    <= agu_be;
          sq_data[agu_sq_i]  <= agu_data;
        end
      end else if (agu_valid) begin
        if (lq[agu_lq_i].state == LQ_ALLOC && !lq_kill[agu_lq_i]) begin
          lq[agu_lq_i].state <= LQ_ADDR;
          lq_addr[agu_lq_i]  <= agu_addr;
          lq_be[agu_lq_i]    <= agu_be;
        end
      end

      if (commit_store && sq[sq_cmt_i].state == SQ_ADDR) begin
        sq[sq_cmt_i].state <= SQ_COMMITTED;
        sq_cmt             <= sq_cmt + SQ_PW'(1);
      end
      if (commit_load && lq[lq_head_i].state == LQ_DONE) begin
        lq[lq_head_i].state <= LQ_FREE;
        lq_head             <= lq_head + LQ_PW'(1);
      end

      if (resp_go) begin
        lq[dc_resp_lq_idx].state <= LQ_DONE;
        ld_wb_valid <= 1'b1;
        ld_wb_tag   <= lq_tag[dc_resp_lq_idx];
        ld_wb_data  <= dc_resp_data;
      end else if (fwd_go) begin
        lq[ld_sel].state <= LQ_DONE;
        ld_wb_valid <= 1'b1;
        ld_wb_tag   <= lq_tag[ld_sel];
        ld_wb_data  <= fwd_data;
      end

      if (st_go) begin
        dc_req_valid  <= 1'b1;
        dc_req_write  <= 1'b1;
        dc_req_addr   <= sq_addr[sq_head_i];
        dc_req_be     <= sq_be[sq_head_i];
        dc_req_data   <= sq_data[sq_head_i];
        dc_req_lq_idx <= '0;
      end else if (ld_go) begin
        dc_req_valid     <= 1'b1;
        dc_req_write     <= 1'b0;
        dc_req_addr      <= lq_addr[ld_sel];
        dc_req_be        <= lq_be[ld_sel];
        dc_req_data      <= '0;
        dc_req_lq_idx    <= ld_sel;
        lq[ld_sel].state <= LQ_ISSUED;
      end

      if (drain) begin
        sq[sq_head_i].state <= SQ_FREE;
        sq_head             <= sq_head + SQ_PW'(1);
      end

      if (alloc_fire && alloc_is_store) begin
        sq[sq_tail_i].state <= SQ_ALLOC;
        sq_tail             <= sq_tail + SQ_PW'(1);
      end else if (alloc_fire) begin
        lq[lq_tail_i].state <= LQ_ALLOC;
        lq_tag[lq_tail_i]   <= alloc_tag;
        lq_snap[lq_tail_i]  <= sq_tail;
        lq_tail             <= lq_tail + LQ_PW'(1);
      end

      if (flush_valid) begin
        lq_tail <= flush_lq_tail;
        sq_tail <= flush_sq_tail;
        for (int i = 0; i < LQ_DEPTH; i++) if (lq_kill[i]) lq[i].state <= LQ_FREE;
        for (int j = 0; j < SQ_DEPTH; j++) if (sq_kill[j]) sq[j].state <= SQ_FREE;
      end
    end
  end

endmodule
